// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared state type and sizing helpers for the SIPO deserializer
package sipo_pkg;

  typedef enum logic {SIPO_EMPTY = 1'b0, SIPO_HOLD = 1'b1} sipo_state_e;

  function automatic int sipo_beats(input int data_width, input int lanes);
    return data_width / lanes;
  endfunction

  function automatic int sipo_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// rtl/sipo_out_reg.sv - single-entry output holding register with valid/ready handshake
module sipo_out_reg import sipo_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             dout_ready,
  output logic             dout_valid,
  output logic [WIDTH-1:0] dout
);

  sipo_state_e state;

  // A load while HOLD replaces the word in place, so a close that meets a handshake never bubbles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SIPO_EMPTY;
      dout  <= '0;
    end else begin
      case (state)
        SIPO_EMPTY: begin
          if (load) begin
            state <= SIPO_HOLD;
            dout  <= load_data;
          end
        end
        SIPO_HOLD: begin
          if (load) begin
            dout <= load_data;
          end else if (dout_ready) begin
            state <= SIPO_EMPTY;
          end
        end
        default: state <= SIPO_EMPTY;
      endcase
    end
  end

  assign dout_valid = (state == SIPO_HOLD);
  assign load_ready = (state == SIPO_EMPTY) || dout_ready;

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - packs LANES-bit beats into DATA_WIDTH-bit words
// SIPO_LAST_EN adds din_last (early close, zero padded) and dout_beats.
module sipo_deserializer import sipo_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [LANES-1:0]      din,
`ifdef SIPO_LAST_EN
  input  logic                  din_last,
  output logic [$clog2(sipo_beats(DATA_WIDTH, LANES)+1)-1:0] dout_beats,
`endif
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int BEATS = sipo_beats(DATA_WIDTH, LANES);
  localparam int CW    = sipo_cnt_w(BEATS);

  if (DATA_WIDTH % LANES != 0) begin : g_width_check
    $error("sipo_deserializer: DATA_WIDTH must be a multiple of LANES");
  end

  logic [CW-1:0]               cnt;
  logic [DATA_WIDTH-1:0]       sh;
  logic [DATA_WIDTH-1:0]       shifted;
  logic [DATA_WIDTH+LANES-1:0] ext;
  logic                        closing;
  logic                        accept;
  logic                        load_ready;

  // Widened concatenation keeps the slices legal even when LANES == DATA_WIDTH.
  always_comb begin
    if (MSB_FIRST) begin
      ext     = {sh, din};
      shifted = ext[DATA_WIDTH-1:0];
    end else begin
      ext     = {din, sh};
      shifted = ext[DATA_WIDTH+LANES-1:LANES];
    end
  end

`ifdef SIPO_LAST_EN
  localparam int BW = $clog2(BEATS + 1);

  logic [BW-1:0]         beats;
  logic [31:0]           pad_bits;
  logic [DATA_WIDTH-1:0] word;

  assign closing = (cnt == CW'(BEATS - 1)) || din_last;
  assign beats   = BW'(cnt) + BW'(1);

  // Pad the missing late beats with zeros as if they had been shifted in.
  always_comb begin
    pad_bits = 32'(BEATS - int'(beats)) * 32'(LANES);
    word     = MSB_FIRST ? (shifted << pad_bits) : (shifted >> pad_bits);
  end

  sipo_out_reg #(.WIDTH(DATA_WIDTH + BW)) u_out (
    .clk        (clk),
    .resetn     (resetn),
    .load       (accept && closing),
    .load_data  ({beats, word}),
    .load_ready (load_ready),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .dout       ({dout_beats, dout})
  );
`else
  assign closing = (cnt == CW'(BEATS - 1));

  sipo_out_reg #(.WIDTH(DATA_WIDTH)) u_out (
    .clk        (clk),
    .resetn     (resetn),
    .load       (accept && closing),
    .load_data  (shifted),
    .load_ready (load_ready),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .dout       (dout)
  );
`endif

  assign din_ready = load_ready || !closing;
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      sh  <= '0;
    end else if (accept) begin
      if (closing) begin
        cnt <= '0;
        sh  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        sh  <= shifted;
      end
    end
  end

endmodule
